// File: rtl/neuron_mac.sv
// neuron_mac: buffered x*w multiply-accumulate neuron
// with bias, optional ReLU, shift and output saturation.
module neuron_mac #(
  parameter int N_ENTRIES = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 20,
  parameter int SHIFT     = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic                             rd_en,
  input  logic                             output_ready,
  input  logic [DATA_W-1:0]                x_in,
  input  logic [DATA_W-1:0]                w_in,
  input  logic [ACC_W-1:0]                 bias,
  input  logic                             relu_en,
  output logic [DATA_W-1:0]                result,
  output logic                             result_valid,
  output logic                             busy,
  output logic [$clog2(N_ENTRIES+1)-1:0]   count,
  output logic                             wr_drop,
  output logic                             sat
);

  localparam int CNT_W = $clog2(N_ENTRIES + 1);
  localparam int DEPTH = 1 << CNT_W;
  localparam int PW    = 2 * DATA_W;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_ENTRIES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] RES_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] RES_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_x [DEPTH];
  logic [DATA_W-1:0] r_w [DEPTH];

  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_idx;
  logic [ACC_W-1:0]  r_acc;
  logic              r_sat;
  logic [DATA_W-1:0] r_result;
  logic              r_wr_drop;

  logic              w_wr_ok;
  logic              w_start;
  logic              w_last;

  logic signed [PW-1:0] w_prod;
  logic [ACC_W:0]       w_sum;
  logic                 w_ovf;
  logic [ACC_W-1:0]     w_acc_nxt;

  logic [ACC_W:0]           w_bsum;
  logic                     w_bovf;
  logic [ACC_W-1:0]         w_v;
  logic signed [ACC_W-1:0]  w_relu;
  logic signed [ACC_W-1:0]  w_sh;
  logic [ACC_W-DATA_W:0]    w_hi;
  logic                     w_fits;
  logic [DATA_W-1:0]        w_res;

  // A write is accepted only in IDLE with room left
  assign w_wr_ok = (r_state == S_IDLE) && wr_en
                && (r_count != FULL);
  // Start also when the same-cycle write makes count nonzero
  assign w_start = (r_state == S_IDLE) && rd_en
                && ((r_count != '0) || w_wr_ok);
  assign w_last  = (r_idx == r_count - ONE);

  // Accumulate step with clamp to the ACC_W signed range
  assign w_prod = $signed(r_x[r_idx]) * $signed(r_w[r_idx]);
  assign w_sum  = {r_acc[ACC_W-1], r_acc}
                + {{(ACC_W+1-PW){w_prod[PW-1]}}, w_prod};
  assign w_ovf  = w_sum[ACC_W] != w_sum[ACC_W-1];
  assign w_acc_nxt = w_ovf
    ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX)
    : w_sum[ACC_W-1:0];

  // Bias add, ReLU, shift, then clamp to DATA_W
  assign w_bsum = {r_acc[ACC_W-1], r_acc}
                + {bias[ACC_W-1], bias};
  assign w_bovf = w_bsum[ACC_W] != w_bsum[ACC_W-1];
  assign w_v    = w_bovf
    ? (w_bsum[ACC_W] ? ACC_MIN : ACC_MAX)
    : w_bsum[ACC_W-1:0];
  assign w_relu = (relu_en && w_v[ACC_W-1])
    ? '0 : $signed(w_v);
  assign w_sh   = w_relu >>> SHIFT;
  assign w_hi   = w_sh[ACC_W-1:DATA_W-1];
  assign w_fits = (&w_hi) || !(|w_hi);
  assign w_res  = w_fits
    ? w_sh[DATA_W-1:0]
    : (w_sh[ACC_W-1] ? RES_MIN : RES_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_last) w_state_nxt = S_BIAS;
      S_BIAS:  w_state_nxt = S_DONE;
      S_DONE:  if (output_ready) w_state_nxt = S_IDLE;
    endcase
  end

  // Operand buffer; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_x[r_count] <= x_in;
      r_w[r_count] <= w_in;
    end
  end

  // Count, accumulator, flags and result register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_result  <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= wr_en && !w_wr_ok;
      if (w_wr_ok) r_count <= r_count + ONE;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_acc <= '0;
            r_sat <= 1'b0;
            r_idx <= '0;
          end
        end
        S_ACCUM: begin
          r_acc <= w_acc_nxt;
          r_idx <= r_idx + ONE;
          if (w_ovf) r_sat <= 1'b1;
        end
        S_BIAS: begin
          r_result <= w_res;
          if (w_bovf || !w_fits) r_sat <= 1'b1;
        end
        S_DONE: begin
          if (output_ready) r_count <= '0;
        end
      endcase
    end
  end

  assign result       = r_result;
  assign result_valid = (r_state == S_DONE);
  assign busy         = (r_state == S_ACCUM)
                     || (r_state == S_BIAS);
  assign count        = r_count;
  assign wr_drop      = r_wr_drop;
  assign sat          = r_sat;

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed vector table plus
// hand sequences for overflow, reset and same-cycle cases.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic        rd_en;
  logic        output_ready;
  logic [7:0]  x_in;
  logic [7:0]  w_in;
  logic [19:0] bias;
  logic        relu_en;
  logic [7:0]  result;
  logic        result_valid;
  logic        busy;
  logic [2:0]  count;
  logic        wr_drop;
  logic        sat;

  int ncmp = 0;
  int nerr = 0;

  neuron_mac #(
    .N_ENTRIES(4),
    .DATA_W(8),
    .ACC_W(20),
    .SHIFT(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .output_ready(output_ready),
    .x_in(x_in),
    .w_in(w_in),
    .bias(bias),
    .relu_en(relu_en),
    .result(result),
    .result_valid(result_valid),
    .busy(busy),
    .count(count),
    .wr_drop(wr_drop),
    .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [3:0][7:0] xs;
    logic [3:0][7:0] ws;
    int              b;
    bit              relu;
    int              exp;
    bit              esat;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(
    int n, int x0, int w0, int x1, int w1,
    int x2, int w2, int x3, int w3,
    int b, bit relu, int exp, bit esat);
    vec_t v;
    v.n = n;
    v.xs[0] = 8'(x0); v.ws[0] = 8'(w0);
    v.xs[1] = 8'(x1); v.ws[1] = 8'(w1);
    v.xs[2] = 8'(x2); v.ws[2] = 8'(w2);
    v.xs[3] = 8'(x3); v.ws[3] = 8'(w3);
    v.b = b;
    v.relu = relu;
    v.exp = exp;
    v.esat = esat;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr_pair(int x, int w);
    @(negedge clk);
    wr_en = 1'b1;
    x_in = 8'(x);
    w_in = 8'(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_rd();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Edges since start_rd was driven, and busy cycles seen
  task automatic wait_valid(output int lat, output int bc);
    lat = 1;
    bc = 0;
    while (!result_valid && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    output_ready = 1'b1;
    @(negedge clk);
    output_ready = 1'b0;
    chk("valid_after_ready", int'(result_valid), 0);
    chk("count_after_ready", int'(count), 0);
  endtask

  task automatic run_vec(int id, vec_t v);
    int lat;
    int bc;
    bias = 20'(v.b);
    relu_en = v.relu;
    for (int i = 0; i < v.n; i++)
      wr_pair(int'($signed(v.xs[i])), int'($signed(v.ws[i])));
    chk($sformatf("v%0d_count", id), int'(count), v.n);
    start_rd();
    wait_valid(lat, bc);
    chk($sformatf("v%0d_latency", id), lat, v.n + 2);
    chk($sformatf("v%0d_busy_cycles", id), bc, v.n + 1);
    chk($sformatf("v%0d_result", id),
        int'($signed(result)), v.exp);
    chk($sformatf("v%0d_sat", id), int'(sat), int'(v.esat));
    @(negedge clk);
    chk($sformatf("v%0d_hold", id),
        int'($signed(result)), v.exp);
    chk($sformatf("v%0d_valid_hold", id),
        int'(result_valid), 1);
    consume();
  endtask

  initial begin
    int lat;
    int bc;

    tbl[0] = mk(3, 2,3, 4,5, -1,6, 0,0, 0, 0, 20, 0);
    tbl[1] = mk(1, -3,5, 0,0, 0,0, 0,0, 0, 0, -15, 0);
    tbl[2] = mk(1, -3,5, 0,0, 0,0, 0,0, 0, 1, 0, 0);
    tbl[3] = mk(4, 127,127, 127,127, 127,127, 127,127,
                0, 0, 127, 1);
    tbl[4] = mk(1, 10,10, 0,0, 0,0, 0,0, -50, 0, 50, 0);
    tbl[5] = mk(4, -128,127, -128,127, -128,127, -128,127,
                0, 0, -128, 1);
    tbl[6] = mk(1, 1,1, 0,0, 0,0, 0,0, 1000, 0, 127, 1);
    tbl[7] = mk(2, -5,7, 3,-2, 0,0, 0,0, 10, 0, -31, 0);
    tbl[8] = mk(2, -5,7, 3,-2, 0,0, 0,0, 10, 1, 0, 0);
    tbl[9] = mk(1, 127,127, 0,0, 0,0, 0,0, 524287, 0, 127, 1);

    reset_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    output_ready = 1'b0;
    x_in = '0;
    w_in = '0;
    bias = '0;
    relu_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_result", int'(result), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_wr_drop", int'(wr_drop), 0);
    chk("rst_sat", int'(sat), 0);

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Empty start is ignored
    start_rd();
    chk("empty_rd_busy", int'(busy), 0);
    @(negedge clk);
    chk("empty_rd_valid", int'(result_valid), 0);
    chk("empty_rd_busy2", int'(busy), 0);

    // Buffer overflow and write during compute
    bias = '0;
    relu_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_pair(1, 1);
      chk($sformatf("ovf_drop%0d", i), int'(wr_drop),
          (i == 4) ? 1 : 0);
    end
    chk("ovf_count", int'(count), 4);
    @(negedge clk);
    chk("ovf_drop_once", int'(wr_drop), 0);
    start_rd();
    chk("accum_busy", int'(busy), 1);
    wr_pair(9, 9);
    chk("accum_wr_drop", int'(wr_drop), 1);
    chk("accum_count", int'(count), 4);
    wait_valid(lat, bc);
    chk("ovf_result_valid", int'(result_valid), 1);
    chk("ovf_result", int'($signed(result)), 4);
    @(negedge clk);
    output_ready = 1'b1;
    @(negedge clk);
    output_ready = 1'b0;
    chk("ovf_consumed", int'(result_valid), 0);

    // Reset in the middle of ACCUM
    wr_pair(3, 3);
    wr_pair(3, 3);
    wr_pair(3, 3);
    start_rd();
    chk("mid_busy", int'(busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(result_valid), 0);
    chk("mid_rst_sat", int'(sat), 0);
    @(negedge clk);
    chk("mid_rst_idle", int'(busy), 0);

    // Same-cycle write and start
    wr_pair(1, 1);
    @(negedge clk);
    wr_en = 1'b1;
    rd_en = 1'b1;
    x_in = 8'd2;
    w_in = 8'd2;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("both_count", int'(count), 2);
    chk("both_wr_drop", int'(wr_drop), 0);
    wait_valid(lat, bc);
    chk("both_latency", lat, 4);
    chk("both_result", int'($signed(result)), 5);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 4, meaning operand buffer depth (x,w pairs).
REQ-002 SHALL have parameter DATA_W, default 8, meaning signed width of x, w and result.
REQ-003 SHALL have parameter ACC_W, default 20, meaning signed accumulator width, ACC_W >= 2*DATA_W.
REQ-004 SHALL have parameter SHIFT, default 0, meaning arithmetic right shift applied before output saturation.
REQ-005 SHALL have ports, one per line:
- clk  input  1  clock.
- reset_n  input  1  reset, synchronous and active-low.
- wr_en  input  1  write-pair strobe from control stage.
- rd_en  input  1  start-compute strobe from control stage.
- output_ready  input  1  result-consumed strobe from control stage.
- x_in  input  DATA_W  signed activation.
- w_in  input  DATA_W  signed weight.
- bias  input  ACC_W  signed bias, sampled in state BIAS.
- relu_en  input  1  ReLU enable, sampled in state BIAS.
- result  output  DATA_W  signed neuron output.
- result_valid  output  1  result holds valid data.
- busy  output  1  high in ACCUM and BIAS.
- count  output  clog2(N_ENTRIES+1)  stored pair count.
- wr_drop  output  1  one-cycle pulse: write rejected.
- sat  output  1  sticky saturation flag for current result.

Function
REQ-006 SHALL implement FSM states IDLE, ACCUM, BIAS, DONE.
REQ-007 IDLE: wr_en with count < N_ENTRIES SHALL store (x_in,w_in) at index count; count increments.
REQ-008 wr_en with count == N_ENTRIES, or in any state other than IDLE, SHALL drop the pair and pulse wr_drop for one cycle.
REQ-009 IDLE: rd_en with count > 0 SHALL clear the accumulator and sat, set index to 0, and enter ACCUM.
REQ-010 IDLE: rd_en with count == 0 SHALL be ignored; state stays IDLE.
REQ-011 Simultaneous wr_en and rd_en in IDLE SHALL store the pair first; the computation includes it (K = count+1).
REQ-012 ACCUM SHALL process one pair per cycle, acc <= sat(acc + x[i]*w[i]) using a full 2*DATA_W signed product, for i = 0..K-1, then enter BIAS.
REQ-013 Accumulator overflow SHALL clamp to +/-(2^(ACC_W-1)) limits (max 2^(ACC_W-1)-1) and set sat.
REQ-014 BIAS (one cycle) SHALL compute v = sat_ACC(acc + bias), apply ReLU if relu_en (v<0 -> 0), arithmetic-shift right by SHIFT, saturate to DATA_W signed (setting sat on clamp), register result, and enter DONE.
REQ-015 result_valid SHALL be high exactly while in DONE; result SHALL hold stable in DONE.
REQ-016 Latency: rd_en sampled at edge t with K pairs -> result_valid high after edge t+K+2.
REQ-017 DONE: output_ready SHALL clear result_valid, reset count to 0, and return to IDLE on the next edge.
REQ-018 output_ready outside DONE and rd_en outside IDLE SHALL be ignored.
REQ-019 busy SHALL equal (state == ACCUM or state == BIAS).

Reset
REQ-020 reset_n low at a clock edge SHALL force IDLE, count=0, result=0, result_valid=0, busy=0, wr_drop=0, sat=0, accumulator=0, in any state including mid-ACCUM.
REQ-021 Buffer contents need no reset; they are unreadable while count=0.

Verification
REQ-022 Write (2,3),(4,5),(-1,6), bias=0, relu_en=0, rd_en -> busy for 4 cycles, result_valid after edge t+5, result=20, sat=0.
REQ-023 Write (-3,5), bias=0: relu_en=0 -> result=-15; repeat with relu_en=1 -> result=0.
REQ-024 Write 4x(127,127), bias=0 -> acc=64516, result=127, sat=1; output_ready -> result_valid=0, count=0.
REQ-025 Five wr_en pulses in IDLE -> count=4, wr_drop pulses once on 5th; wr_en during ACCUM -> wr_drop pulse, count unchanged.
REQ-026 rd_en with count=0 -> stays IDLE, busy=0; reset_n low during ACCUM -> next cycle IDLE, count=0, result_valid=0.
REQ-027 wr_en and rd_en same cycle with count=1 holding (1,1), new pair (2,2) -> K=2, result=5.
